// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared widths, ACK encoding and FSM states for the I2C target
package i2c_target_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_target_responder_line_sync.sv
// i2c_line_sync: scl/sda synchronizers, registered edge strobes and START/STOP detection
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_bit,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic scl_h, sda_h, scl_c, sda_c;
  assign scl_c = scl_s[SYNC_STAGES-1];
  assign sda_c = sda_s[SYNC_STAGES-1];
  // reset preloads the live pin levels so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s <= {SYNC_STAGES{scl}};
      sda_s <= {SYNC_STAGES{sda}};
      scl_h <= scl;
      sda_h <= sda;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      sda_bit <= 1'b1;
      start <= 1'b0;
      stop <= 1'b0;
    end else begin
      scl_s <= {scl_s[SYNC_STAGES-2:0], scl};
      sda_s <= {sda_s[SYNC_STAGES-2:0], sda};
      scl_h <= scl_c;
      sda_h <= sda_c;
      scl_rise <= scl_c & ~scl_h;
      scl_fall <= ~scl_c & scl_h;
      sda_bit <= sda_c;
      start <= scl_c & scl_h & ~sda_c & sda_h;
      stop <= scl_c & scl_h & sda_c & ~sda_h;
    end
  end
endmodule

// File: rtl/i2c_target_responder.sv
// i2c_target_responder: 7-bit address I2C target with byte-wide write/read handshake
module i2c_target_responder
  import i2c_target_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
  input  logic i_rx_ready,
  input  logic [I2C_BYTE_W-1:0] i_tx_data,
  output logic [I2C_BYTE_W-1:0] o_rx_data,
  output logic o_rx_dv,
  output logic o_tx_req,
  output logic o_addr_match,
  output logic o_rw,
  output logic o_busy,
  output logic o_stop
);
  state_t state;
  logic [2:0] bit_cnt;
  logic [I2C_BYTE_W-1:0] shreg, in_byte;
  logic sda_oe, pend, last, scl_rise, scl_fall, sda_bit, start, stop;
  assign sda = sda_oe ? ACK : 1'bz;
  assign in_byte = {shreg[I2C_BYTE_W-2:0], sda_bit};
  assign last = bit_cnt == 3'd7;
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_bit(sda_bit),
    .start(start), .stop(stop)
  );
  // pend marks an ACK or read reload owed on the next scl_fall
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= 3'd0;
      shreg <= '0;
      sda_oe <= 1'b0;
      pend <= 1'b0;
      o_rx_data <= '0;
      o_rx_dv <= 1'b0;
      o_tx_req <= 1'b0;
      o_addr_match <= 1'b0;
      o_rw <= 1'b0;
      o_busy <= 1'b0;
      o_stop <= 1'b0;
    end else begin
      o_rx_dv <= 1'b0;
      o_tx_req <= 1'b0;
      o_addr_match <= 1'b0;
      o_stop <= 1'b0;
      if (start) begin
        state <= ADDR;
        bit_cnt <= 3'd0;
        sda_oe <= 1'b0;
        pend <= 1'b0;
      end else if (stop) begin
        state <= IDLE;
        o_stop <= 1'b1;
        o_busy <= 1'b0;
        sda_oe <= 1'b0;
        pend <= 1'b0;
      end else begin
        case (state)
          ADDR:
            if (scl_rise && !pend) begin
              shreg <= in_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last && in_byte[7:1] == TARGET_ADDR) begin
                pend <= 1'b1;
                o_addr_match <= 1'b1;
                o_rw <= in_byte[0];
                o_busy <= 1'b1;
              end else if (last) begin
                state <= WAIT_STOP;
                o_busy <= 1'b0;
              end
            end else if (scl_fall && pend) begin
              pend <= 1'b0;
              sda_oe <= 1'b1;
              state <= ADDR_ACK;
            end
          ADDR_ACK:
            if (scl_fall && o_rw) begin
              o_tx_req <= 1'b1;
              shreg <= {i_tx_data[6:0], 1'b0};
              sda_oe <= ~i_tx_data[7];
              bit_cnt <= 3'd0;
              state <= RD_DATA;
            end else if (scl_fall) begin
              sda_oe <= 1'b0;
              state <= WR_DATA;
            end
          WR_DATA:
            if (scl_rise && !pend) begin
              shreg <= in_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last && i_rx_ready) begin
                o_rx_data <= in_byte;
                o_rx_dv <= 1'b1;
                pend <= 1'b1;
              end else if (last) begin
                state <= WAIT_STOP;
                o_busy <= 1'b0;
              end
            end else if (scl_fall && pend) begin
              pend <= 1'b0;
              sda_oe <= 1'b1;
              state <= WR_ACK;
            end
          WR_ACK:
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state <= WR_DATA;
            end
          RD_DATA:
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              sda_oe <= last ? 1'b0 : ~shreg[7];
              shreg <= {shreg[6:0], 1'b0};
              state <= last ? RD_ACK : RD_DATA;
            end
          RD_ACK:
            if (scl_rise && !pend) begin
              if (sda_bit == NACK) begin
                state <= WAIT_STOP;
                o_busy <= 1'b0;
              end else pend <= 1'b1;
            end else if (scl_fall && pend) begin
              pend <= 1'b0;
              o_tx_req <= 1'b1;
              shreg <= {i_tx_data[6:0], 1'b0};
              sda_oe <= ~i_tx_data[7];
              bit_cnt <= 3'd0;
              state <= RD_DATA;
            end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_responder.sv
// tb_i2c_target_responder: directed open-drain I2C master driving the target through each scenario
module tb_i2c_target_responder;
  localparam int Q = 5;
  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1, rx_ready = 1'b1;
  wire sda;
  logic [7:0] tx_tab [8];
  logic [7:0] rx_data, rx_log [16];
  logic rx_dv, tx_req, addr_match, rw, busy, stp, ack;
  logic [7:0] d;
  int total = 0, bad = 0, am_n = 0, dv_n = 0, tr_n = 0, st_n = 0, drv_n = 0;
  int am0, dv0, tr0, st0, drv0;
  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;
  always #5 clk = ~clk;
  i2c_target_responder dut (
    .clk(clk), .rst(rst), .scl(m_scl), .sda(sda), .i_rx_ready(rx_ready),
    .i_tx_data(tx_tab[tr_n % 8]), .o_rx_data(rx_data), .o_rx_dv(rx_dv),
    .o_tx_req(tx_req), .o_addr_match(addr_match), .o_rw(rw), .o_busy(busy), .o_stop(stp)
  );
  always @(negedge clk) begin
    if (addr_match) am_n++;
    if (stp) st_n++;
    if (tx_req) tr_n++;
    if (sda === 1'b0 && m_sda) drv_n++;
    if (rx_dv) begin
      rx_log[dv_n % 16] = rx_data;
      dv_n++;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    am0 = am_n; dv0 = dv_n; tr0 = tr_n; st0 = st_n; drv0 = drv_n;
  endtask
  task automatic i2c_start();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask
  task automatic i2c_rstart();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2 * Q);
  endtask
  task automatic bit_xfer(input logic b, output logic r);
    m_sda = b; tick(Q);
    m_scl = 1'b1; tick(Q);
    r = sda;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic a);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, a);
  endtask
  task automatic rd_byte(input logic a, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      v[i] = r;
    end
    bit_xfer(a, r);
  endtask
  initial begin
    tx_tab[0] = 8'h5A; tx_tab[1] = 8'h81; tx_tab[2] = 8'hEE; tx_tab[3] = 8'h00;
    tx_tab[4] = 8'hFF; tx_tab[5] = 8'hFF; tx_tab[6] = 8'hFF; tx_tab[7] = 8'hFF;
    tick(5);
    rst = 1'b0;
    tick(5);
    chk("reset_busy", busy, 0);
    chk("reset_rw", rw, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_sda", sda, 1);
    chk("reset_pulses", {addr_match, rx_dv, tx_req, stp}, 0);
    // plain write of two bytes
    snap();
    i2c_start();
    wr_byte(8'hA0, ack); chk("wr_addr_ack", ack, 0);
    chk("wr_busy", busy, 1);
    chk("wr_rw", rw, 0);
    wr_byte(8'h3C, ack); chk("wr_d0_ack", ack, 0);
    wr_byte(8'hC3, ack); chk("wr_d1_ack", ack, 0);
    i2c_stop();
    chk("wr_match_cnt", am_n - am0, 1);
    chk("wr_dv_cnt", dv_n - dv0, 2);
    chk("wr_byte0", rx_log[dv0 % 16], 8'h3C);
    chk("wr_byte1", rx_log[(dv0 + 1) % 16], 8'hC3);
    chk("wr_rx_data_hold", rx_data, 8'hC3);
    chk("wr_stop_cnt", st_n - st0, 1);
    chk("wr_busy_after_stop", busy, 0);
    // read two bytes, ACK then NACK
    snap();
    i2c_start();
    wr_byte(8'hA1, ack); chk("rd_addr_ack", ack, 0);
    chk("rd_rw", rw, 1);
    rd_byte(1'b0, d); chk("rd_byte0", d, 8'h5A);
    rd_byte(1'b1, d); chk("rd_byte1", d, 8'h81);
    chk("rd_busy_after_nack", busy, 0);
    drv0 = drv_n;
    wr_byte(8'hFF, ack); chk("rd_after_nack_ack", ack, 1);
    chk("rd_after_nack_drive", drv_n - drv0, 0);
    i2c_stop();
    chk("rd_tx_req_cnt", tr_n - tr0, 2);
    chk("rd_rw_hold", rw, 1);
    // address mismatch
    snap();
    i2c_start();
    wr_byte(8'hA2, ack); chk("mm_addr_nack", ack, 1);
    wr_byte(8'h00, ack); chk("mm_data_nack", ack, 1);
    chk("mm_busy", busy, 0);
    chk("mm_drive", drv_n - drv0, 0);
    chk("mm_pulses", (am_n - am0) + (dv_n - dv0) + (tr_n - tr0), 0);
    i2c_stop();
    // sink backpressure NACKs the data byte
    snap();
    i2c_start();
    wr_byte(8'hA0, ack); chk("bp_addr_ack", ack, 0);
    rx_ready = 1'b0;
    wr_byte(8'h77, ack); chk("bp_data_nack", ack, 1);
    chk("bp_no_dv", dv_n - dv0, 0);
    chk("bp_busy", busy, 0);
    rx_ready = 1'b1;
    wr_byte(8'h12, ack); chk("bp_wait_stop_nack", ack, 1);
    chk("bp_still_no_dv", dv_n - dv0, 0);
    i2c_stop();
    chk("bp_stop_cnt", st_n - st0, 1);
    // write then repeated START into a read
    snap();
    i2c_start();
    wr_byte(8'hA0, ack); chk("sr_wr_addr_ack", ack, 0);
    chk("sr_rw0", rw, 0);
    wr_byte(8'h10, ack); chk("sr_wr_data_ack", ack, 0);
    i2c_rstart();
    wr_byte(8'hA1, ack); chk("sr_rd_addr_ack", ack, 0);
    chk("sr_rw1", rw, 1);
    rd_byte(1'b1, d); chk("sr_rd_byte", d, 8'hEE);
    i2c_stop();
    chk("sr_match_cnt", am_n - am0, 2);
    chk("sr_wr_byte", rx_log[dv0 % 16], 8'h10);
    // reset while the target drives a read bit
    snap();
    i2c_start();
    wr_byte(8'hA1, ack); chk("rr_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, ack);
    chk("rr_driving_before_reset", sda, 0);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(1);
    chk("rr_sda_released", sda, 1);
    chk("rr_outputs", {busy, rw, rx_dv, tx_req, addr_match, stp}, 0);
    drv0 = drv_n;
    for (int i = 0; i < 6; i++) bit_xfer(1'b1, ack);
    chk("rr_ignores_bus", drv_n - drv0, 0);
    am0 = am_n;
    i2c_rstart();
    wr_byte(8'hA0, ack); chk("rr_readdr_ack", ack, 0);
    chk("rr_readdr_match", am_n - am0, 1);
    i2c_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
